// File: rtl/hit_retrieval_reader.sv
// SSID query front end for the hit store: walks HNM -> HCM -> HIM reads and streams the stored hits oldest-first.
// Optional READER_STATS_EN adds saturating query/miss counters.
module hit_retrieval_reader #(
    parameter int SSIDBITS         = 16,
    parameter int COLINDEXBITS_HNM = 6,
    parameter int HITINFOBITS      = 8,
    parameter int MAXHITNBITS      = 4,
    parameter int ROWINDEXBITS_HIM = 10,
    parameter int HITSPERROW       = 4,
    parameter int NCOLS_HCM        = 14
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 storageBusy,
    input  logic [SSIDBITS-1:0]                  querySSID,
    input  logic                                 queryValid,
    output logic                                 queryReady,
    output logic [SSIDBITS-COLINDEXBITS_HNM-1:0] rowIndex_HNM,
    input  logic [(1<<COLINDEXBITS_HNM)-1:0]     dataOut_HNM,
    output logic [SSIDBITS-1:0]                  rowIndex_HCM,
    input  logic [NCOLS_HCM-1:0]                 dataOut_HCM,
    output logic [ROWINDEXBITS_HIM-1:0]          rowIndex_HIM,
    input  logic [HITSPERROW*HITINFOBITS-1:0]    dataOut_HIM,
    output logic [HITINFOBITS-1:0]               hitInfo,
    output logic                                 hitValid,
    input  logic                                 hitReady,
    output logic                                 hitLast,
    output logic                                 hitTruncated,
    output logic                                 missValid
`ifdef READER_STATS_EN
    ,
    output logic [15:0]                          queryCount,
    output logic [15:0]                          missCount
`endif
);

    localparam int NCOLS_HIM = HITSPERROW * HITINFOBITS;
    localparam int IDXW      = $clog2(HITSPERROW) + 1;

    typedef enum logic [2:0] {
        IDLE, HNM_WAIT, HNM_CHECK, HCM_WAIT, HCM_CHECK, HIM_WAIT, HIM_LOAD, STREAM
    } state_t;

    state_t                 state;
    logic [SSIDBITS-1:0]    ssid;
    logic [MAXHITNBITS-1:0] count;
    logic [NCOLS_HIM-1:0]   hbuf;
    logic [IDXW-1:0]        n;
    logic [IDXW-1:0]        idx;
    logic                   trunc;

    logic [MAXHITNBITS-1:0] hcm_count;
    logic                   load_trunc;
    logic [IDXW-1:0]        load_n;
    logic [IDXW-1:0]        nxt;
    logic                   accept;

    assign hcm_count  = dataOut_HCM[MAXHITNBITS-1:0];
    assign load_trunc = count > MAXHITNBITS'(HITSPERROW);
    assign load_n     = load_trunc ? IDXW'(HITSPERROW) : IDXW'(count);
    assign nxt        = idx + 1'b1;
    assign queryReady = (state == IDLE) && !storageBusy && !reset;
    assign accept     = queryValid && queryReady;

    // Records are packed newest-at-bottom, so record i lives at slot n-1-i.
    function automatic logic [HITINFOBITS-1:0] rec(input logic [NCOLS_HIM-1:0] d,
                                                   input logic [IDXW-1:0] sel);
        return d[int'(sel)*HITINFOBITS +: HITINFOBITS];
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            ssid         <= '0;
            count        <= '0;
            hbuf         <= '0;
            n            <= '0;
            idx          <= '0;
            trunc        <= 1'b0;
            rowIndex_HNM <= '0;
            rowIndex_HCM <= '0;
            rowIndex_HIM <= '0;
            hitInfo      <= '0;
            hitValid     <= 1'b0;
            hitLast      <= 1'b0;
            hitTruncated <= 1'b0;
            missValid    <= 1'b0;
        end else begin
            missValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ssid         <= querySSID;
                        rowIndex_HNM <= querySSID[SSIDBITS-1:COLINDEXBITS_HNM];
                        state        <= HNM_WAIT;
                    end
                end
                HNM_WAIT: state <= HNM_CHECK;
                HNM_CHECK: begin
                    if (dataOut_HNM[ssid[COLINDEXBITS_HNM-1:0]]) begin
                        rowIndex_HCM <= ssid;
                        state        <= HCM_WAIT;
                    end else begin
                        missValid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                HCM_WAIT: state <= HCM_CHECK;
                HCM_CHECK: begin
                    count <= hcm_count;
                    if (hcm_count == '0) begin
                        missValid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        rowIndex_HIM <= dataOut_HCM[NCOLS_HCM-1 -: ROWINDEXBITS_HIM];
                        state        <= HIM_WAIT;
                    end
                end
                HIM_WAIT: state <= HIM_LOAD;
                HIM_LOAD: begin
                    hbuf         <= dataOut_HIM;
                    n            <= load_n;
                    trunc        <= load_trunc;
                    idx          <= '0;
                    hitValid     <= 1'b1;
                    hitInfo      <= rec(dataOut_HIM, load_n - 1'b1);
                    hitLast      <= (load_n == IDXW'(1));
                    hitTruncated <= load_trunc && (load_n == IDXW'(1));
                    state        <= STREAM;
                end
                STREAM: begin
                    if (hitReady) begin
                        if (hitLast) begin
                            hitValid     <= 1'b0;
                            hitLast      <= 1'b0;
                            hitTruncated <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            idx          <= nxt;
                            hitInfo      <= rec(hbuf, n - 1'b1 - nxt);
                            hitLast      <= (nxt == n - 1'b1);
                            hitTruncated <= trunc && (nxt == n - 1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef READER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            queryCount <= '0;
            missCount  <= '0;
        end else begin
            if (accept && queryCount != 16'hFFFF)
                queryCount <= queryCount + 16'd1;
            if (missValid && missCount != 16'hFFFF)
                missCount <= missCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hit_retrieval_reader.sv
// Directed bench for hit_retrieval_reader: table of queries against modelled 1-cycle-latency memories,
// plus backpressure, storageBusy and mid-stream reset sequences.
module tb_hit_retrieval_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        storageBusy;
    logic [15:0] querySSID;
    logic        queryValid;
    logic        queryReady;
    logic [9:0]  rowIndex_HNM;
    logic [63:0] dataOut_HNM;
    logic [15:0] rowIndex_HCM;
    logic [13:0] dataOut_HCM;
    logic [9:0]  rowIndex_HIM;
    logic [31:0] dataOut_HIM;
    logic [7:0]  hitInfo;
    logic        hitValid;
    logic        hitReady;
    logic        hitLast;
    logic        hitTruncated;
    logic        missValid;

    always #5 clock = ~clock;

    hit_retrieval_reader dut (
        .clock(clock), .reset(reset), .storageBusy(storageBusy),
        .querySSID(querySSID), .queryValid(queryValid), .queryReady(queryReady),
        .rowIndex_HNM(rowIndex_HNM), .dataOut_HNM(dataOut_HNM),
        .rowIndex_HCM(rowIndex_HCM), .dataOut_HCM(dataOut_HCM),
        .rowIndex_HIM(rowIndex_HIM), .dataOut_HIM(dataOut_HIM),
        .hitInfo(hitInfo), .hitValid(hitValid), .hitReady(hitReady),
        .hitLast(hitLast), .hitTruncated(hitTruncated), .missValid(missValid)
    );

    logic [63:0] hnm_mem [0:1023];
    logic [13:0] hcm_mem [0:65535];
    logic [31:0] him_mem [0:1023];

    always @(posedge clock) begin
        dataOut_HNM <= hnm_mem[rowIndex_HNM];
        dataOut_HCM <= hcm_mem[rowIndex_HCM];
        dataOut_HIM <= him_mem[rowIndex_HIM];
    end

    typedef struct {
        logic [15:0] ssid;
        logic        hnm_set;
        logic [13:0] hcm;       // {HIM addr[9:0], count[3:0]}
        logic [31:0] him;
        int          miss_cyc;  // negedge index after accept where missValid is seen, -1 none
        int          n;         // records expected
        logic [31:0] recs;      // expected records, first in [31:24]
        logic        trunc;
    } vec_t;

    vec_t vt [8];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic load_mem(input vec_t v);
        hnm_mem[v.ssid[15:6]][v.ssid[5:0]] = v.hnm_set;
        hcm_mem[v.ssid] = v.hcm;
        him_mem[v.hcm[13:4]] = v.him;
    endtask

    task automatic run_query(input vec_t v, input int stall_idx, input int stall_len,
                             input int busy_cycles, input logic [9:0] prev_row);
        int  c = 0, nh = 0, stalls = 0, miss_cyc = -1, first_hit = -1, misses = 0;
        bit  prev_stall = 0;
        load_mem(v);
        @(negedge clock);
        hitReady    = 1'b1;
        querySSID   = v.ssid;
        queryValid  = 1'b1;
        storageBusy = (busy_cycles > 0);
        for (int b = 0; b < busy_cycles; b++) begin
            #1;
            chk("busy_ready", {31'd0, queryReady}, 32'd0);
            chk("busy_row", {22'd0, rowIndex_HNM}, {22'd0, prev_row});
            @(negedge clock);
        end
        storageBusy = 1'b0;
        #1;
        chk("ready", {31'd0, queryReady}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        queryValid = 1'b0;
        chk("row_hnm", {22'd0, rowIndex_HNM}, {22'd0, v.ssid[15:6]});
        while (c < 30) begin
            if (missValid) begin
                if (miss_cyc < 0) miss_cyc = c;
                misses++;
            end
            if (prev_stall) chk("hold_valid", {31'd0, hitValid}, 32'd1);
            prev_stall = 0;
            if (hitValid) begin
                if (first_hit < 0) first_hit = c;
                if (nh >= v.n) begin
                    chk("extra_hit", nh, v.n);
                    hitReady = 1'b1;
                end else if (nh == stall_idx && stalls < stall_len) begin
                    hitReady = 1'b0;
                    chk("held_info", {24'd0, hitInfo}, {24'd0, v.recs[(3-nh)*8 +: 8]});
                    stalls++;
                    prev_stall = 1;
                end else begin
                    hitReady = 1'b1;
                    chk("rec", {24'd0, hitInfo}, {24'd0, v.recs[(3-nh)*8 +: 8]});
                    chk("last", {31'd0, hitLast}, {31'd0, (nh == v.n - 1)});
                    chk("trunc", {31'd0, hitTruncated}, {31'd0, (nh == v.n - 1) && v.trunc});
                    nh++;
                end
            end else begin
                hitReady = 1'b1;
            end
            @(negedge clock);
            c++;
        end
        hitReady = 1'b1;
        chk("miss_cyc", miss_cyc, v.miss_cyc);
        chk("misses", misses, (v.miss_cyc >= 0) ? 1 : 0);
        chk("nhits", nh, v.n);
        if (v.n > 0) chk("first_hit", first_hit, 6);
        if (stall_len > 0) chk("stalls", stalls, stall_len);
        chk("ready_after", {31'd0, queryReady}, 32'd1);
    endtask

    initial begin
        int c;
        int seen;
        for (int i = 0; i < 1024; i++) begin
            hnm_mem[i] = '0;
            him_mem[i] = '0;
        end
        for (int i = 0; i < 65536; i++) hcm_mem[i] = '0;

        vt[0] = '{16'h0285, 1'b0, {10'h000, 4'd0}, 32'h0,        2, 0, 32'h0,        1'b0};
        vt[1] = '{16'h0285, 1'b1, {10'h012, 4'd3}, 32'h00AABBCC, -1, 3, 32'hAABBCC00, 1'b0};
        vt[2] = '{16'h1234, 1'b1, {10'h055, 4'd6}, 32'h11223344, -1, 4, 32'h11223344, 1'b1};
        vt[3] = '{16'h0040, 1'b1, {10'h100, 4'd0}, 32'h0,        4, 0, 32'h0,        1'b0};
        vt[4] = '{16'hFFFF, 1'b1, {10'h3FF, 4'd4}, 32'hDEADBEEF, -1, 4, 32'hDEADBEEF, 1'b0};
        vt[5] = '{16'h0001, 1'b1, {10'h000, 4'd1}, 32'h12345678, -1, 1, 32'h78000000, 1'b0};
        vt[6] = '{16'h8000, 1'b1, {10'h2A0, 4'd5}, 32'hCAFEF00D, -1, 4, 32'hCAFEF00D, 1'b1};
        vt[7] = '{16'h0286, 1'b0, {10'h000, 4'd0}, 32'h0,        2, 0, 32'h0,        1'b0};

        reset = 1'b1; storageBusy = 1'b0; querySSID = '0; queryValid = 1'b0; hitReady = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_ready", {31'd0, queryReady}, 32'd0);
        chk("rst_outs", {hitValid, hitLast, hitTruncated, missValid}, 32'd0);
        chk("rst_rows", {rowIndex_HNM, rowIndex_HIM}, 32'd0);
        chk("rst_row_hcm", {16'd0, rowIndex_HCM}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", {31'd0, queryReady}, 32'd1);

        for (int i = 0; i < 8; i++) run_query(vt[i], -1, 0, 0, 10'h0);

        // BB held for three stalled cycles
        run_query(vt[1], 1, 3, 0, 10'h0);
        // storageBusy blocks acceptance; last HNM row was 0x0A
        run_query(vt[2], -1, 0, 3, 10'h00A);

        // reset while streaming, right after the first record is taken
        load_mem(vt[2]);
        @(negedge clock);
        querySSID = vt[2].ssid; queryValid = 1'b1; hitReady = 1'b1;
        @(posedge clock);
        @(negedge clock);
        queryValid = 1'b0;
        c = 0;
        while (!hitValid && c < 20) begin
            @(negedge clock);
            c++;
        end
        chk("rs_first_valid", {31'd0, hitValid}, 32'd1);
        @(negedge clock);
        chk("rs_rec1", {24'd0, hitInfo}, 32'h22);
        reset = 1'b1;
        @(negedge clock);
        chk("rs_outs", {hitValid, hitLast, hitTruncated, missValid}, 32'd0);
        chk("rs_rows", {rowIndex_HNM, rowIndex_HIM}, 32'd0);
        chk("rs_info", {24'd0, hitInfo}, 32'd0);
        chk("rs_ready", {31'd0, queryReady}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("rs_ready_after", {31'd0, queryReady}, 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (hitValid || missValid || hitLast) seen++;
            @(negedge clock);
        end
        chk("rs_quiet", seen, 0);
        run_query(vt[1], -1, 0, 0, 10'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
